// File: rtl/matmul_pkg.sv
// Shared types and default widths for the matmul APB master and its command FIFO.
package matmul_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;
  localparam int DEFAULT_BUS_WIDTH  = 32;
  localparam int DEFAULT_ADDR_WIDTH = 16;
  localparam int DEFAULT_STRB_WIDTH = DEFAULT_BUS_WIDTH / DEFAULT_DATA_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_RESP
  } apb_mst_state_e;

  // Command layout at default widths; the master packs its FIFO entries in this field order.
  typedef struct packed {
    logic                          write;
    logic [DEFAULT_ADDR_WIDTH-1:0] addr;
    logic [DEFAULT_BUS_WIDTH-1:0]  wdata;
    logic [DEFAULT_STRB_WIDTH-1:0] strb;
  } apb_cmd_t;

endpackage

// File: rtl/matmul_cmd_fifo.sv
// Synchronous command FIFO with power-of-two depth; the extra pointer bit
// separates the full and empty conditions.
module matmul_cmd_fifo
  import matmul_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      r_wr_ptr;
  logic [AW:0]      r_rd_ptr;
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full    = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                     (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;
  assign o_rdata   = r_mem[r_rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/matmul_apb_master.sv
// APB master that drains a command FIFO one transfer at a time and returns
// one response per command, with an ACCESS-phase timeout.
module matmul_apb_master
  import matmul_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int BUS_WIDTH   = DEFAULT_BUS_WIDTH,
  parameter int ADDR_WIDTH  = DEFAULT_ADDR_WIDTH,
  parameter int FIFO_DEPTH  = 4,
  parameter int TIMEOUT_CYC = 16
) (
  input  logic                            clk_i,
  input  logic                            rst_i,
  input  logic                            req_valid_i,
  output logic                            req_ready_o,
  input  logic                            req_write_i,
  input  logic [ADDR_WIDTH-1:0]           req_addr_i,
  input  logic [BUS_WIDTH-1:0]            req_wdata_i,
  input  logic [BUS_WIDTH/DATA_WIDTH-1:0] req_strb_i,
  output logic                            rsp_valid_o,
  input  logic                            rsp_ready_i,
  output logic [BUS_WIDTH-1:0]            rsp_rdata_o,
  output logic                            rsp_err_o,
  output logic                            psel_o,
  output logic                            penable_o,
  output logic                            pwrite_o,
  output logic [ADDR_WIDTH-1:0]           paddr_o,
  output logic [BUS_WIDTH-1:0]            pwdata_o,
  output logic [BUS_WIDTH/DATA_WIDTH-1:0] pstrb_o,
  input  logic                            pready_i,
  input  logic                            pslverr_i,
  input  logic [BUS_WIDTH-1:0]            prdata_i,
  output logic                            busy_o
);

  localparam int STRB_WIDTH = BUS_WIDTH / DATA_WIDTH;
  localparam int CMD_WIDTH  = 1 + ADDR_WIDTH + BUS_WIDTH + STRB_WIDTH;
  localparam int TW         = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYC - 1);

  apb_mst_state_e r_state;
  apb_mst_state_e w_next;

  logic                  w_fifo_full;
  logic                  w_fifo_empty;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_complete;
  logic                  w_timeout;
  logic [CMD_WIDTH-1:0]  w_fifo_wdata;
  logic [CMD_WIDTH-1:0]  w_fifo_rdata;
  logic                  w_cmd_write;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic [BUS_WIDTH-1:0]  w_cmd_wdata;
  logic [STRB_WIDTH-1:0] w_cmd_strb;

  logic                  r_psel;
  logic                  r_penable;
  logic                  r_pwrite;
  logic [ADDR_WIDTH-1:0] r_paddr;
  logic [BUS_WIDTH-1:0]  r_pwdata;
  logic [STRB_WIDTH-1:0] r_pstrb;
  logic                  r_rsp_valid;
  logic [BUS_WIDTH-1:0]  r_rsp_rdata;
  logic                  r_rsp_err;
  logic [TW-1:0]         r_timer;

  assign req_ready_o  = !w_fifo_full;
  assign w_push       = req_valid_i && !w_fifo_full;
  assign w_fifo_wdata = {req_write_i, req_addr_i, req_wdata_i, req_strb_i};
  assign {w_cmd_write, w_cmd_addr, w_cmd_wdata, w_cmd_strb} = w_fifo_rdata;

  matmul_cmd_fifo #(
    .WIDTH (CMD_WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_cmd_fifo (
    .i_clk   (clk_i),
    .i_rst   (rst_i),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_fifo_wdata),
    .o_rdata (w_fifo_rdata),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) r_state <= ST_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next     = r_state;
    w_pop      = 1'b0;
    w_complete = 1'b0;
    w_timeout  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_fifo_empty) begin
          w_next = ST_SETUP;
          w_pop  = 1'b1;
        end
      end
      ST_SETUP: w_next = ST_ACCESS;
      ST_ACCESS: begin
        if (pready_i) begin
          w_complete = 1'b1;
          w_next     = ST_RESP;
        end else if (r_timer == TIMER_LAST) begin
          w_timeout = 1'b1;
          w_next    = ST_RESP;
        end
      end
      ST_RESP: begin
        // Back-to-back commands skip IDLE and pop on the handshake edge.
        if (rsp_ready_i) begin
          if (!w_fifo_empty) begin
            w_next = ST_SETUP;
            w_pop  = 1'b1;
          end else begin
            w_next = ST_IDLE;
          end
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_pwrite    <= 1'b0;
      r_paddr     <= '0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
      r_timer     <= '0;
    end else begin
      if (r_state == ST_RESP && rsp_ready_i) r_rsp_valid <= 1'b0;
      if (w_pop) begin
        r_psel    <= 1'b1;
        r_penable <= 1'b0;
        r_pwrite  <= w_cmd_write;
        r_paddr   <= w_cmd_addr;
        r_pwdata  <= w_cmd_write ? w_cmd_wdata : '0;
        r_pstrb   <= w_cmd_write ? w_cmd_strb : '0;
      end else if (r_state == ST_SETUP) begin
        r_penable <= 1'b1;
      end else if (w_complete || w_timeout) begin
        r_psel      <= 1'b0;
        r_penable   <= 1'b0;
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= (w_complete && !r_pwrite) ? prdata_i : '0;
        r_rsp_err   <= w_complete ? pslverr_i : 1'b1;
      end
      // Counts completed ACCESS cycles; restarts for every new transfer.
      if (r_state == ST_ACCESS && w_next == ST_ACCESS) r_timer <= r_timer + TW'(1);
      else                                             r_timer <= '0;
    end
  end

  assign psel_o      = r_psel;
  assign penable_o   = r_penable;
  assign pwrite_o    = r_pwrite;
  assign paddr_o     = r_paddr;
  assign pwdata_o    = r_pwdata;
  assign pstrb_o     = r_pstrb;
  assign rsp_valid_o = r_rsp_valid;
  assign rsp_rdata_o = r_rsp_rdata;
  assign rsp_err_o   = r_rsp_err;
  assign busy_o      = !w_fifo_empty || (r_state != ST_IDLE) || r_rsp_valid;

endmodule
